mc_core_sequencer: RTL
======================

// Module: mc_core_sequencer
// PURPOSE
//  Multi-cycle control FSM for the RV32I core: sequences fetch, decode, execute, memory and writeback around the
//  combinational decoder, ALU and register file. Drives IR/PC/RF write enables and the next-PC select, and handshakes
//  with instruction and data memory ports (req held until ready). Also counts retired instructions.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter instret (wraps modulo 2^CNT_W)
// PORTS
//  clk          in   1      core clock; all state changes on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  run          in   1      1 = execute instructions; 0 = park in IDLE after the current instruction retires
//  opcode       in   7      instr[6:0] from the instruction register (valid from DECODE onward)
//  br_taken     in   1      branch comparator result for the current instruction (valid in EXEC)
//  imem_req     out  1      instruction fetch request
//  imem_ready   in   1      fetch data valid this cycle
//  dmem_req     out  1      data memory request
//  dmem_we      out  1      1 = store, 0 = load (meaningful only while dmem_req=1)
//  dmem_ready   in   1      data access completes this cycle
//  ir_we        out  1      load instruction register
//  pc_we        out  1      update PC from the next-PC mux
//  pc_sel       out  2      next-PC select: 0 PC+4, 1 PC+imm_b, 2 PC+imm_j, 3 (rs1+imm_i)&~1
//  rf_we        out  1      register-file write strobe
//  retired      out  1      one-cycle pulse when an instruction completes
//  busy         out  1      1 in every state except IDLE
//  instret      out  CNT_W  retired-instruction count
//  trap         out  1      illegal-opcode flag (present only with MC_SEQ_TRAP_EN)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; instret=0; outstanding requests drop immediately (no completion awaited).
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, (TRAP).
//  IDLE: run=1 -> FETCH next cycle.
//  FETCH: imem_req=1 until imem_ready=1; in the ready cycle ir_we=1 -> DECODE. No timeout.
//  DECODE: 1 cycle; opcode classified -> EXEC.
//  EXEC (1 cycle), by opcode:
//   - arith (0110011/0010011), lui, auipc -> WB, pc_sel=0.
//   - load/store -> MEM.
//   - branch: pc_we=1, pc_sel=br_taken?1:0, retired=1 -> FETCH/IDLE.
//   - jal -> WB, pc_sel=2; jalr -> WB, pc_sel=3.
//  MEM: dmem_req=1, dmem_we=(store); both held stable until dmem_ready=1.
//   - store completes: pc_we=1, pc_sel=0, retired=1 -> FETCH/IDLE.
//   - load completes -> WB.
//  WB: rf_we=1, pc_we=1, pc_sel latched from EXEC, retired=1 -> FETCH if run else IDLE.
//  pc_sel is registered and held from EXEC until the pc_we cycle; 0 elsewhere.
//  Strobes ir_we, pc_we, rf_we, retired are exactly one cycle per instruction.
//  instret increments on each retired pulse and wraps to 0 after all-ones.
//  run is sampled only at retire and in IDLE; deassertion mid-instruction never aborts it.
//  Minimum latency with zero-wait ready (ready in the first req cycle): ALU op = 4 cycles, load = 5, store = 4,
//  branch = 3.
// CONFIGURATION
//  MC_SEQ_TRAP_EN defined: an unrecognised opcode in EXEC -> TRAP. In TRAP: trap=1, busy=1, no strobes, no retire.
//   TRAP is exited only by reset.
//  MC_SEQ_TRAP_EN undefined: an unrecognised opcode executes as a NOP (pc_we=1, pc_sel=0, retired=1 in EXEC).
//   The trap port is absent.
// STRUCTURE
//  Shared package: state encoding, pc_sel encodings (PCS_SEQ/BR/JAL/JALR). Opcode constants reuse the core's
//  existing opcode definitions.
//  Sub-module: retire_counter (CNT_W-bit, async-reset, inc on retired). FSM and output decode stay in this module.
// TESTING
//  1. add x1,x2,x3 with imem_ready=1 in the first FETCH cycle -> ir_we@1, rf_we+pc_we(sel 0)+retired@4;
//     instret 0->1.
//  2. lw with dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 held 4 cycles; WB follows;
//     exactly one rf_we; total 8 cycles.
//  3. beq with br_taken=1, then br_taken=0 -> pc_sel=1, then 0, with pc_we in EXEC; rf_we never set.
//  4. run dropped during MEM of a sw -> store completes, retired=1, state IDLE, busy=0, no further imem_req.
//  5. rst_n low during FETCH with imem_req=1 -> imem_req=0 immediately, instret=0, IDLE after release.
//  6. opcode 7'b1111111 -> with MC_SEQ_TRAP_EN: trap=1 sticky, instret unchanged; without: NOP retire, PC+4.

Source files
------------

// File: rtl/mc_core_sequencer_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: FSM states, pc_sel codes,
// RV32I base opcodes and the opcode classifier used in DECODE.
package mc_core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  localparam logic [1:0] PCS_SEQ  = 2'd0;
  localparam logic [1:0] PCS_BR   = 2'd1;
  localparam logic [1:0] PCS_JAL  = 2'd2;
  localparam logic [1:0] PCS_JALR = 2'd3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_ILLEGAL
  } iclass_e;

  function automatic iclass_e classify(input logic [6:0] op);
    case (op)
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC: return CL_ALU;
      OP_LOAD:                         return CL_LOAD;
      OP_STORE:                        return CL_STORE;
      OP_BRANCH:                       return CL_BRANCH;
      OP_JAL:                          return CL_JAL;
      OP_JALR:                         return CL_JALR;
      default:                         return CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mc_core_sequencer_retire_counter.sv
// Retired-instruction counter: increments on each retire pulse, wraps modulo 2^CNT_W.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mc_core_sequencer.sv
// Multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb) with retire counter.
// Define MC_SEQ_TRAP_EN to trap on unrecognised opcodes instead of executing them as NOPs.
module mc_core_sequencer
  import mc_core_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic             retired,
  output logic             busy,
  output logic [CNT_W-1:0] instret
`ifdef MC_SEQ_TRAP_EN
  ,
  output logic             trap
`endif
);

  state_e     state_q, state_d;
  iclass_e    cls_q, cls_d;
  logic [1:0] pcsel_q, pcsel_d;
  state_e     after_retire;

  assign after_retire = run ? ST_FETCH : ST_IDLE;
  assign busy         = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    pcsel_d  = pcsel_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PCS_SEQ;
    rf_we    = 1'b0;
    retired  = 1'b0;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cls_d   = classify(opcode);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // pcsel_q only reaches the port in MEM/WB, so a stale value elsewhere is harmless
        case (cls_q)
          CL_ALU:   begin pc_sel = PCS_SEQ;  state_d = ST_WB;  end
          CL_LOAD,
          CL_STORE: begin pc_sel = PCS_SEQ;  state_d = ST_MEM; end
          CL_JAL:   begin pc_sel = PCS_JAL;  state_d = ST_WB;  end
          CL_JALR:  begin pc_sel = PCS_JALR; state_d = ST_WB;  end
          CL_BRANCH: begin
            pc_sel  = br_taken ? PCS_BR : PCS_SEQ;
            pc_we   = 1'b1;
            retired = 1'b1;
            state_d = after_retire;
          end
          default: begin
`ifdef MC_SEQ_TRAP_EN
            state_d = ST_TRAP;
`else
            pc_we   = 1'b1;
            retired = 1'b1;
            state_d = after_retire;
`endif
          end
        endcase
        pcsel_d = pc_sel;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CL_STORE);
        pc_sel   = pcsel_q;
        if (dmem_ready) begin
          if (cls_q == CL_STORE) begin
            pc_we   = 1'b1;
            retired = 1'b1;
            state_d = after_retire;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = pcsel_q;
        retired = 1'b1;
        state_d = after_retire;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cls_q   <= CL_ALU;
      pcsel_q <= PCS_SEQ;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      pcsel_q <= pcsel_d;
    end
  end

`ifdef MC_SEQ_TRAP_EN
  assign trap = (state_q == ST_TRAP);
`endif

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retired),
    .cnt   (instret)
  );

endmodule
